terminal_inject_arbiter: RTL and testbench

Round-robin injection arbiter placed in front of one mesh terminal input port. It shares the port's single `pndng_i_in`/`data_out_i_in`/`popin` channel between `NUM_REQ` local source FIFOs. It holds one packet in an output register and refills it in the same cycle the mesh pops, so sustained throughput is one packet per cycle. Per-requester served counters and a sticky protocol-error flag support the scoreboard and checker.

---
 rtl/terminal_inject_arbiter_pkg.sv | 20 ++
 rtl/terminal_inject_arbiter_if.sv | 40 ++++
 rtl/terminal_inject_arbiter_rr_pick.sv | 31 +++
 rtl/terminal_inject_arbiter.sv | 79 +++++++
 tb/tb_terminal_inject_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/terminal_inject_arbiter_pkg.sv
// Shared types and helpers for the terminal injection arbiter and its checkers.
package inject_arb_pkg;

    // Output register occupancy: EMPTY holds nothing, FULL holds one packet.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Default packet width matching the mesh pckg_sz; the top re-declares its
    // own packet type from its PAKG_SIZE parameter.
    localparam int PKT_W_DEF = 32;
    typedef logic [PKT_W_DEF-1:0] pkt_t;

    // Round-robin successor: the source after ptr, wrapping at num_req.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
        return (ptr + 1 >= num_req) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/terminal_inject_arbiter_if.sv
// Bundle of the source-FIFO side, mesh-terminal side and status signals.
//
// Handshake: a source offers a packet by holding req_pndng_i[k]=1 with its head
// on slice k of req_data_i; the arbiter takes it in any cycle it drives
// req_pop_o[k]=1 (only ever while req_pndng_i[k]=1). Toward the mesh,
// term_pndng_o=1 means term_data_o is valid and is held unchanged until the
// mesh pulses term_pop_i, which consumes it at that clock edge.
interface terminal_inject_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int PAKG_SIZE = 32,
    parameter int CNT_W     = 16
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_pndng_i;
    logic [NUM_REQ*PAKG_SIZE-1:0] req_data_i;
    logic [NUM_REQ-1:0]           req_pop_o;
    logic                         term_pndng_o;
    logic [PAKG_SIZE-1:0]         term_data_o;
    logic                         term_pop_i;
    logic [IDX_W-1:0]             grant_id_o;
    logic [NUM_REQ*CNT_W-1:0]     served_cnt_o;
    logic                         err_o;
    inject_arb_pkg::state_e       state_o;      // debug view of the occupancy FSM

    // Arbiter side.
    modport slave (
        input  req_pndng_i, req_data_i, term_pop_i,
        output req_pop_o, term_pndng_o, term_data_o, grant_id_o,
               served_cnt_o, err_o, state_o
    );

    // Environment side (sources, mesh, checkers).
    modport master (
        output req_pndng_i, req_data_i, term_pop_i,
        input  req_pop_o, term_pndng_o, term_data_o, grant_id_o,
               served_cnt_o, err_o, state_o
    );

endinterface

// File: rtl/terminal_inject_arbiter_rr_pick.sv
// Combinational cyclic priority picker: first asserted request at or after ptr.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    logic [IDX_W-1:0] idx;

    // Walk the sources starting at ptr and take the first pending one.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/terminal_inject_arbiter.sv
// Round-robin injection arbiter feeding one mesh terminal input port from
// NUM_REQ source FIFOs through a single output register.
module terminal_inject_arbiter
    import inject_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int PAKG_SIZE = 32,
    parameter int CNT_W     = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    terminal_inject_arbiter_if.slave  arb_io
);

    localparam int IDX_W = $clog2(NUM_REQ);
    typedef logic [PAKG_SIZE-1:0] term_pkt_t;

    state_e           state_q;
    term_pkt_t        data_q;
    logic [IDX_W-1:0] gid_q;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q [NUM_REQ];
    logic             err_q;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               load;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (arb_io.req_pndng_i),
        .ptr        (ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    // Refill when the register is free or being drained this cycle; reset wins.
    always_comb begin
        load = ((state_q == ST_EMPTY) || arb_io.term_pop_i) && pick_any && !rst_i;
        arb_io.req_pop_o = load ? pick_onehot : '0;
    end

    // Output register, round-robin pointer, served counters and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
        end else begin
            if (load) begin
                state_q         <= ST_FULL;
                data_q          <= arb_io.req_data_i[int'(pick_idx)*PAKG_SIZE +: PAKG_SIZE];
                gid_q           <= pick_idx;
                ptr_q           <= IDX_W'(rr_next(int'(pick_idx), NUM_REQ));
                cnt_q[pick_idx] <= cnt_q[pick_idx] + 1'b1;
            end else if (state_q == ST_FULL && arb_io.term_pop_i) begin
                state_q <= ST_EMPTY;
            end
            // A pop with nothing offered is a mesh protocol violation.
            if (state_q == ST_EMPTY && arb_io.term_pop_i) err_q <= 1'b1;
        end
    end

    // Drive registered outputs and flatten the counter array.
    always_comb begin
        arb_io.term_pndng_o = (state_q == ST_FULL);
        arb_io.term_data_o  = data_q;
        arb_io.grant_id_o   = gid_q;
        arb_io.err_o        = err_q;
        arb_io.state_o      = state_q;
        arb_io.served_cnt_o = '0;
        for (int k = 0; k < NUM_REQ; k++) arb_io.served_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
    end

endmodule

// File: tb/tb_terminal_inject_arbiter.sv
// Bench for terminal_inject_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbiter.
module tb_terminal_inject_arbiter;
    localparam int N  = 4;
    localparam int PW = 32;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    terminal_inject_arbiter_if #(.NUM_REQ(N), .PAKG_SIZE(PW), .CNT_W(CW)) bus ();

    terminal_inject_arbiter #(.NUM_REQ(N), .PAKG_SIZE(PW), .CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .arb_io (bus)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];       // expected grant order when enabled
    bit         sb_on = 1'b0;

    logic [PW-1:0] stim_data [N];

    // Reference model: occupancy, held packet, next-priority source, counts.
    bit            m_full;
    logic [PW-1:0] m_data;
    int            m_gid;
    int            m_ptr;
    logic [CW-1:0] m_cnt [N];
    bit            m_err;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Winner under round-robin: first pending source scanning from m_ptr; -1 if none.
    function automatic int model_winner(input logic [N-1:0] pnd);
        for (int o = 0; o < N; o++) begin
            if (pnd[(m_ptr + o) % N]) return (m_ptr + o) % N;
        end
        return -1;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic [N-1:0] pnd, input logic pop, input logic rst);
        int w;
        logic [N-1:0] exp_pop;
        int obs_g;
        @(negedge clk);
        rst_i = rst;
        bus.req_pndng_i = pnd;
        bus.term_pop_i  = pop;
        for (int k = 0; k < N; k++) bus.req_data_i[k*PW +: PW] = stim_data[k];
        #1;
        w = -1;
        if (!rst && (!m_full || pop)) w = model_winner(pnd);
        exp_pop = '0;
        if (w >= 0) exp_pop[w] = 1'b1;
        check_val("req_pop", 64'(bus.req_pop_o), 64'(exp_pop));
        if (sb_on && bus.req_pop_o != '0) begin
            obs_g = 0;
            for (int k = 0; k < N; k++) if (bus.req_pop_o[k]) obs_g = k;
            if (exp_q.size() == 0) check_val("grant_order_extra", 64'(obs_g), 64'hFFFF);
            else check_val("grant_order", 64'(obs_g), 64'(exp_q.pop_front()));
        end
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_data = '0; m_gid = 0; m_ptr = 0; m_err = 0;
            for (int k = 0; k < N; k++) m_cnt[k] = '0;
        end else begin
            if (!m_full && pop) m_err = 1;
            if (w >= 0) begin
                m_full = 1; m_data = stim_data[w]; m_gid = w;
                m_ptr = (w + 1) % N; m_cnt[w] = m_cnt[w] + 1'b1;
            end else if (m_full && pop) begin
                m_full = 0;
            end
        end
        #1;
        check_val("term_pndng", 64'(bus.term_pndng_o), 64'(m_full));
        check_val("state", 64'(bus.state_o), 64'(m_full));
        check_val("err", 64'(bus.err_o), 64'(m_err));
        if (m_full || rst) begin
            check_val("term_data", 64'(bus.term_data_o), 64'(m_data));
            check_val("grant_id", 64'(bus.grant_id_o), 64'(m_gid));
        end
        for (int k = 0; k < N; k++)
            check_val("served_cnt", 64'(bus.served_cnt_o[k*CW +: CW]), 64'(m_cnt[k]));
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) stim_data[k] = $urandom();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.req_pndng_i = '0;
        bus.req_data_i  = '0;
        bus.term_pop_i  = 1'b0;
        for (int k = 0; k < N; k++) stim_data[k] = '0;
        m_full = 0; m_data = '0; m_gid = 0; m_ptr = 0; m_err = 0;
        for (int k = 0; k < N; k++) m_cnt[k] = '0;

        // Reset then idle: everything zero, no pops.
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step('0, 1'b0, 1'b0);
        check_val("idle_data", 64'(bus.term_data_o), 64'h0);
        check_val("idle_err", 64'(bus.err_o), 64'h0);

        // Only source 2 pending, mesh pops every cycle.
        stim_data[2] = 32'hA5A5_0002;
        step(4'b0100, 1'b1, 1'b0);
        check_val("src2_data", 64'(bus.term_data_o), 64'hA5A5_0002);
        check_val("src2_gid", 64'(bus.grant_id_o), 64'd2);
        check_val("src2_cnt", 64'(bus.served_cnt_o[2*CW +: CW]), 64'd1);
        step('0, 1'b1, 1'b0);   // drain

        // Fairness: all sources pending for 12 grants from a fresh pointer.
        step('0, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) for (int k = 0; k < N; k++) exp_q.push_back(2'(k));
        sb_on = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_data();
            step(4'hF, 1'b1, 1'b0);
            check_val("rr_no_bubble", 64'(bus.term_pndng_o), 64'd1);
        end
        sb_on = 1'b0;
        check_val("rr_order_left", 64'(exp_q.size()), 64'd0);
        for (int k = 0; k < N; k++)
            check_val("rr_cnt", 64'(bus.served_cnt_o[k*CW +: CW]), 64'd3);

        // Mesh withholds pop for 20 cycles while FULL: contents frozen.
        for (int i = 0; i < 20; i++) begin
            rand_data();
            step(4'hF, 1'b0, 1'b0);
            check_val("hold_nopop", 64'(bus.req_pop_o), 64'h0);
        end

        // Pop while EMPTY: sticky error until reset.
        step('0, 1'b0, 1'b1);
        step('0, 1'b1, 1'b0);
        check_val("err_set", 64'(bus.err_o), 64'd1);
        for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0);
        check_val("err_sticky", 64'(bus.err_o), 64'd1);
        check_val("err_empty", 64'(bus.term_pndng_o), 64'd0);

        // Reset while FULL with source 1 pending.
        step('0, 1'b0, 1'b1);
        stim_data[3] = 32'h3333_0003;
        step(4'b1000, 1'b0, 1'b0);
        stim_data[1] = 32'h1111_0001;
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b1);
        check_val("rstfull_pndng", 64'(bus.term_pndng_o), 64'd0);
        step(4'b0010, 1'b0, 1'b0);
        check_val("rstfull_gid", 64'(bus.grant_id_o), 64'd1);
        check_val("rstfull_data", 64'(bus.term_data_o), 64'h1111_0001);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rand_data();
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 59) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
